// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : divider_pkg
// Purpose : Shared types and sizing helpers for the Q-format divider.
//           state_t  - controller states (IDLE, DIV, FIX)
//           ITER     - number of restoring iterations for a sample width
//           MAXV     - largest positive output value for a sample width
//           MINV     - most negative output value for a sample width
// Revision: 1.0 - initial release
// ============================================================================
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // The dividend is |in1| scaled by 2^(BITSIZE-2), so it is 2*BITSIZE-2 bits
   // wide and needs one iteration per bit.
   function automatic int ITER(input int bitsize);
      return 2 * bitsize - 2;
   endfunction

   function automatic int MAXV(input int bitsize);
      return (1 << (bitsize - 1)) - 1;
   endfunction

   function automatic int MINV(input int bitsize);
      return -(1 << (bitsize - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
// Module  : divider_if
// Purpose : Sample-side bundle of the divider.
//           lrclk  - sample strobe (rising edge starts a division)
//           in1    - signed numerator
//           in2    - signed denominator
//           out    - signed quotient, registered
//           valid  - one-cycle pulse when out updates
//           busy   - division in progress
//           sat    - result was clamped (only with DIVIDER_SAT_FLAG_EN)
//           Modports: master (sample source), slave (divider).
// Revision: 1.0 - initial release
// ============================================================================
interface divider_if #(
   parameter int BITSIZE = 16
);
   logic                      lrclk;
   logic signed [BITSIZE-1:0] in1;
   logic signed [BITSIZE-1:0] in2;
   logic signed [BITSIZE-1:0] out;
   logic                      valid;
   logic                      busy;
`ifdef DIVIDER_SAT_FLAG_EN
   logic                      sat;

   modport master (output lrclk, in1, in2, input  out, valid, busy, sat);
   modport slave  (input  lrclk, in1, in2, output out, valid, busy, sat);
`else
   modport master (output lrclk, in1, in2, input  out, valid, busy);
   modport slave  (input  lrclk, in1, in2, output out, valid, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/divider_core.sv
`default_nettype none
// ============================================================================
// Module  : divider_core
// Purpose : Unsigned restoring shift-subtract divider, one quotient bit per
//           step. The controller loads operands, then issues ITER(BITSIZE)
//           steps; hold keeps the counter running but freezes the datapath.
// Ports   : bclk      - clock
//           resetn    - asynchronous active-low reset
//           load      - capture dividend/divisor, clear remainder/quotient
//           step      - perform one iteration
//           hold      - skip the datapath update for this step
//           dividend  - unsigned dividend, 2*BITSIZE-2 bits
//           divisor   - unsigned divisor, BITSIZE bits
//           quotient  - unsigned quotient, 2*BITSIZE-2 bits
//           done      - high on the final step
// Revision: 1.0 - initial release
// ============================================================================
module divider_core
   import divider_pkg::*;
#(
   parameter int BITSIZE = 16
) (
   input  wire logic                      bclk,
   input  wire logic                      resetn,
   input  wire logic                      load,
   input  wire logic                      step,
   input  wire logic                      hold,
   input  wire logic [2*BITSIZE-3:0]      dividend,
   input  wire logic [BITSIZE-1:0]        divisor,
   output logic      [2*BITSIZE-3:0]      quotient,
   output logic                           done
);

   localparam int N  = ITER(BITSIZE);
   localparam int DW = 2 * BITSIZE - 2;
   localparam int CW = $clog2(N + 1);
   localparam int RW = BITSIZE + 1;

   logic [RW-1:0]  r_rem;
   logic [DW-1:0]  r_dvd;
   logic [DW-1:0]  r_quo;
   logic [BITSIZE-1:0] r_div;
   logic [CW-1:0]  r_cnt;

   // Remainder shifted left with the next dividend MSB appended. One extra
   // bit of headroom keeps the comparison exact for every remainder value.
   logic [RW:0]    w_shift;
   logic           w_ge;
   logic [RW-1:0]  w_rem_next;

   always_comb begin
      w_shift    = {r_rem, r_dvd[DW-1]};
      w_ge       = (w_shift >= {2'b00, r_div});
      w_rem_next = w_ge ? RW'(w_shift - {2'b00, r_div}) : w_shift[RW-1:0];
   end

   always_ff @(posedge bclk or negedge resetn) begin
      if (!resetn) begin
         r_rem <= '0;
         r_dvd <= '0;
         r_quo <= '0;
         r_div <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_rem <= '0;
         r_dvd <= dividend;
         r_quo <= '0;
         r_div <= divisor;
         r_cnt <= '0;
      end else if (step) begin
         r_cnt <= r_cnt + 1'b1;
         if (!hold) begin
            r_rem <= w_rem_next;
            r_dvd <= r_dvd << 1;
            r_quo <= {r_quo[DW-2:0], w_ge};
         end
      end
   end

   assign quotient = r_quo;
   assign done     = step && (r_cnt == CW'(N - 1));

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module  : divider
// Purpose : Sequential signed Q-format divider, out = in1 * 2^(BITSIZE-2) / in2
//           (0x4000 == 1.0 at BITSIZE=16). A rising lrclk seen in the bclk
//           domain starts one division; the result appears ITER+1 bclk later
//           with a one-cycle valid pulse. Results truncate toward zero and
//           saturate to the signed BITSIZE range; x/0 clamps by sign of x.
// Ports   : bclk    - clock (64x lrclk)
//           resetn  - asynchronous active-low reset
//           bus     - divider_if.slave (lrclk, in1, in2, out, valid, busy[, sat])
// Options : DIVIDER_SAT_FLAG_EN - adds bus.sat, set with out when the result
//           was clamped (overflow or nonzero/0).
// Revision: 1.0 - initial release
// ============================================================================
module divider
   import divider_pkg::*;
#(
   parameter int BITSIZE = 16
) (
   input  wire logic bclk,
   input  wire logic resetn,
   divider_if.slave  bus
);

   localparam int DW = 2 * BITSIZE - 2;
   localparam logic [BITSIZE-1:0] MAX_OUT = BITSIZE'(MAXV(BITSIZE));
   localparam logic [BITSIZE-1:0] MIN_OUT = BITSIZE'(MINV(BITSIZE));
   localparam logic [DW-1:0]      MAX_MAG = DW'(MAXV(BITSIZE));
   localparam logic [DW-1:0]      MIN_MAG = DW'(-MINV(BITSIZE));

   state_t             r_state;
   logic               r_lrclk_q;
   logic               r_sign;
   logic               r_div0;
   logic               r_num_zero;
   logic [BITSIZE-1:0] r_out;
   logic               r_valid;
   logic               r_busy;
`ifdef DIVIDER_SAT_FLAG_EN
   logic               r_sat;
   logic               w_sat;
`endif

   logic               w_start;
   logic               w_load;
   logic [BITSIZE-1:0] w_mag_a;
   logic [BITSIZE-1:0] w_mag_b;
   logic [DW-1:0]      w_dividend;
   logic [DW-1:0]      w_quo;
   logic               w_done;
   logic [BITSIZE-1:0] w_result;

   // Magnitudes are BITSIZE-bit unsigned, so the most negative input maps to
   // 2^(BITSIZE-1) exactly.
   always_comb begin
      w_mag_a    = bus.in1[BITSIZE-1] ? (~bus.in1 + 1'b1) : bus.in1;
      w_mag_b    = bus.in2[BITSIZE-1] ? (~bus.in2 + 1'b1) : bus.in2;
      w_dividend = {w_mag_a, {(BITSIZE-2){1'b0}}};
      w_start    = bus.lrclk && !r_lrclk_q;
      w_load     = w_start && (r_state == IDLE);
   end

   divider_core #(
      .BITSIZE (BITSIZE)
   ) u_core (
      .bclk     (bclk),
      .resetn   (resetn),
      .load     (w_load),
      .step     (r_state == DIV),
      .hold     (r_div0),
      .dividend (w_dividend),
      .divisor  (w_mag_b),
      .quotient (w_quo),
      .done     (w_done)
   );

   // Sign, clamp and divide-by-zero handling on the unsigned quotient.
   // Negative results may reach 2^(BITSIZE-1) before clamping.
   always_comb begin
      w_result = '0;
      if (r_div0) begin
         if (r_num_zero)  w_result = '0;
         else if (r_sign) w_result = MIN_OUT;
         else             w_result = MAX_OUT;
      end else if (r_sign) begin
         if (w_quo > MIN_MAG) w_result = MIN_OUT;
         else                 w_result = ~w_quo[BITSIZE-1:0] + 1'b1;
      end else begin
         if (w_quo > MAX_MAG) w_result = MAX_OUT;
         else                 w_result = w_quo[BITSIZE-1:0];
      end
   end

`ifdef DIVIDER_SAT_FLAG_EN
   always_comb begin
      w_sat = 1'b0;
      if (r_div0)      w_sat = !r_num_zero;
      else if (r_sign) w_sat = (w_quo > MIN_MAG);
      else             w_sat = (w_quo > MAX_MAG);
   end
`endif

   // busy trails the state by one cycle so it covers the iteration cycles
   // and the cycle in which valid is presented.
   always_ff @(posedge bclk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_lrclk_q  <= 1'b0;
         r_sign     <= 1'b0;
         r_div0     <= 1'b0;
         r_num_zero <= 1'b0;
         r_out      <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
`ifdef DIVIDER_SAT_FLAG_EN
         r_sat      <= 1'b0;
`endif
      end else begin
         r_lrclk_q <= bus.lrclk;
         r_valid   <= 1'b0;
         r_busy    <= (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_sign     <= bus.in1[BITSIZE-1] ^ bus.in2[BITSIZE-1];
                  r_div0     <= (bus.in2 == '0);
                  r_num_zero <= (bus.in1 == '0);
                  r_state    <= DIV;
               end
            end
            DIV: begin
               if (w_done) r_state <= FIX;
            end
            FIX: begin
               r_out   <= w_result;
               r_valid <= 1'b1;
`ifdef DIVIDER_SAT_FLAG_EN
               r_sat   <= w_sat;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.out   = r_out;
   assign bus.valid = r_valid;
   assign bus.busy  = r_busy;
`ifdef DIVIDER_SAT_FLAG_EN
   assign bus.sat   = r_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider
// Purpose : Directed self-checking bench for divider at BITSIZE=16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divider;

   localparam int BITSIZE = 16;
   localparam int LAT     = 31;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        chk_sat;
      logic        s;
   } vec_t;

   logic bclk = 1'b0;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   divider_if #(.BITSIZE(BITSIZE)) bus ();

   divider #(.BITSIZE(BITSIZE)) dut (
      .bclk   (bclk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 bclk = ~bclk;

   // Start one division and wait (bounded) for the valid pulse.
   task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] res, output logic s);
      @(negedge bclk);
      bus.in1   = a;
      bus.in2   = b;
      bus.lrclk = 1'b1;
      lat = -1;
      res = 16'hxxxx;
      s   = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(posedge bclk); #1;
         if (bus.valid === 1'b1) begin
            lat = k;
            res = bus.out;
`ifdef DIVIDER_SAT_FLAG_EN
            s   = bus.sat;
`endif
            break;
         end
      end
      @(negedge bclk);
      bus.lrclk = 1'b0;
   endtask

   task automatic test_reset;
      resetn    = 1'b0;
      bus.lrclk = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      repeat (3) @(posedge bclk);
      #1;
      checks++; if (bus.out !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h want=0000", bus.out); end
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
`ifdef DIVIDER_SAT_FLAG_EN
      checks++; if (bus.sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", bus.sat); end
`endif
      @(negedge bclk);
      resetn = 1'b1;
      repeat (2) @(negedge bclk);
   endtask

   task automatic test_unity;
      vec_t v [2];
      int lat; logic [15:0] res; logic s;
      v[0] = {16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0};
      v[1] = {16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         do_div(v[i].a, v[i].b, lat, res, s);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL unity_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
         checks++; if (res !== v[i].q) begin failures++; $display("FAIL unity_out[%0d] got=%h want=%h", i, res, v[i].q); end
         if (i == 0) begin
            @(posedge bclk); #1;
            checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL valid_pulse_width got=%b want=0", bus.valid); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b want=0", bus.busy); end
            checks++; if (bus.out !== 16'h4000) begin failures++; $display("FAIL out_hold got=%h want=4000", bus.out); end
         end
      end
   endtask

   task automatic test_signs;
      vec_t v [4];
      int lat; logic [15:0] res; logic s;
      v[0] = {16'h0001, 16'h0003, 16'h1555, 1'b0, 1'b0};
      v[1] = {16'hFFFF, 16'h0003, 16'hEAAB, 1'b0, 1'b0};
      v[2] = {16'hFFFD, 16'h4000, 16'hFFFD, 1'b0, 1'b0};
      v[3] = {16'hC000, 16'h2000, 16'h8000, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         do_div(v[i].a, v[i].b, lat, res, s);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL signs_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
         checks++; if (res !== v[i].q) begin failures++; $display("FAIL signs_out[%0d] got=%h want=%h", i, res, v[i].q); end
`ifdef DIVIDER_SAT_FLAG_EN
         if (v[i].chk_sat) begin
            checks++; if (s !== v[i].s) begin failures++; $display("FAIL signs_sat[%0d] got=%b want=%b", i, s, v[i].s); end
         end
`endif
      end
   endtask

   task automatic test_saturation;
      vec_t v [3];
      int lat; logic [15:0] res; logic s;
      v[0] = {16'h4000, 16'h1000, 16'h7FFF, 1'b1, 1'b1};
      v[1] = {16'h8000, 16'h2000, 16'h8000, 1'b0, 1'b0};
      v[2] = {16'h8000, 16'h1000, 16'h8000, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         do_div(v[i].a, v[i].b, lat, res, s);
         checks++; if (res !== v[i].q) begin failures++; $display("FAIL sat_out[%0d] got=%h want=%h", i, res, v[i].q); end
`ifdef DIVIDER_SAT_FLAG_EN
         if (v[i].chk_sat) begin
            checks++; if (s !== v[i].s) begin failures++; $display("FAIL sat_flag[%0d] got=%b want=%b", i, s, v[i].s); end
         end
`endif
      end
   endtask

   task automatic test_div_zero;
      vec_t v [3];
      int lat; logic [15:0] res; logic s;
      v[0] = {16'h1234, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
      v[1] = {16'hF000, 16'h0000, 16'h8000, 1'b1, 1'b1};
      v[2] = {16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         do_div(v[i].a, v[i].b, lat, res, s);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL div0_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
         checks++; if (res !== v[i].q) begin failures++; $display("FAIL div0_out[%0d] got=%h want=%h", i, res, v[i].q); end
`ifdef DIVIDER_SAT_FLAG_EN
         if (v[i].chk_sat) begin
            checks++; if (s !== v[i].s) begin failures++; $display("FAIL div0_sat[%0d] got=%b want=%b", i, s, v[i].s); end
         end
`endif
      end
   endtask

   // Second lrclk rise at edge 10 and operand change from edge 5 on.
   task automatic test_retrigger;
      int lat;
      logic [15:0] res;
      lat = -1;
      res = 16'hxxxx;
      @(negedge bclk);
      bus.in1   = 16'h0001;
      bus.in2   = 16'h0003;
      bus.lrclk = 1'b1;
      for (int c = 0; c < 64; c++) begin
         @(posedge bclk); #1;
         if (c == 1) begin
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_in_flight got=%b want=1", bus.busy); end
         end
         if (bus.valid === 1'b1) begin
            lat = c;
            res = bus.out;
            break;
         end
         if (c == 3) bus.lrclk = 1'b0;
         if (c == 4) begin
            bus.in1 = 16'h4000;
            bus.in2 = 16'h1000;
         end
         if (c == 9) bus.lrclk = 1'b1;
      end
      @(negedge bclk);
      bus.lrclk = 1'b0;
      checks++; if (lat !== LAT) begin failures++; $display("FAIL retrig_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (res !== 16'h1555) begin failures++; $display("FAIL retrig_out got=%h want=1555", res); end
   endtask

   task automatic test_reset_mid;
      int lat; logic [15:0] res; logic s;
      @(negedge bclk);
      bus.in1   = 16'h2000;
      bus.in2   = 16'h4000;
      bus.lrclk = 1'b1;
      for (int c = 0; c <= 15; c++) begin
         @(posedge bclk); #1;
      end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b want=1", bus.busy); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (bus.out !== 16'h0000) begin failures++; $display("FAIL mid_reset_out got=%h want=0000", bus.out); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b want=0", bus.valid); end
      bus.lrclk = 1'b0;
      repeat (3) @(posedge bclk);
      @(negedge bclk);
      resetn = 1'b1;
      @(negedge bclk);
      do_div(16'h1000, 16'h4000, lat, res, s);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (res !== 16'h1000) begin failures++; $display("FAIL post_reset_out got=%h want=1000", res); end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_signs();
      test_saturation();
      test_div_zero();
      test_retrigger();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
